// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the single-bus CPU sequencer: opcodes, ALU codes, IR fields, states.
package cpu_ctrl_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;
  localparam int C_HI   = 18;
  localparam int C_LO   = 0;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_ROR = 4'd4;
  localparam logic [3:0] ALU_ROL = 4'd5;
  localparam logic [3:0] ALU_SHR = 4'd6;
  localparam logic [3:0] ALU_SHL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  typedef enum logic [3:0] {
    RST = 4'd0, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_RFMT, CL_IMM, CL_UNARY, CL_MULDIV, CL_NOP, CL_HALT, CL_ILLEGAL
  } iclass_t;

  function automatic iclass_t decode_class(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHL: return CL_RFMT;
      OP_ADDI, OP_ANDI, OP_ORI:       return CL_IMM;
      OP_NEG, OP_NOT:                 return CL_UNARY;
      OP_MUL, OP_DIV:                 return CL_MULDIV;
      OP_NOP:                         return CL_NOP;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_ILLEGAL;
    endcase
  endfunction

  // Immediate forms reuse the ALU code of their register counterpart.
  function automatic logic [3:0] alu_code(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_reg_select.sv
// 4-to-16 one-hot general-register decoder; all zeros when disabled.
module reg_select (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving every strobe of the single-bus datapath.
// Outputs are a pure decode of the state register and ir.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        run,
  output logic        illegal,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] R_out,
  output logic [15:0] R_in,
  output logic [3:0]  operation,
  output logic [3:0]  state
);

  state_t     state_q, next_state;
  iclass_t    cls;
  logic [3:0] alu, ra, rb, rc;
  logic [3:0] ro_sel, ri_sel;
  logic       ro_en, ri_en, instr_end;
  logic       unused_ir;

  assign cls       = decode_class(ir[OPC_HI:OPC_LO]);
  assign alu       = alu_code(ir[OPC_HI:OPC_LO]);
  assign ra        = ir[RA_HI:RA_LO];
  assign rb        = ir[RB_HI:RB_LO];
  assign rc        = ir[RC_HI:RC_LO];
  // The constant field is routed to the bus by the datapath; only Cout is generated here.
  assign unused_ir = ^ir[RC_LO-1:C_LO];

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_q <= RST;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    instr_end  = 1'b0;
    illegal    = 1'b0;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; MDRout = 1'b0;  Cout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Zin_low = 1'b0; Zin_high = 1'b0;
    HIin  = 1'b0; LOin = 1'b0;
    operation = ALU_ADD;
    ro_en = 1'b0; ro_sel = '0;
    ri_en = 1'b0; ri_sel = '0;

    case (state_q)
      RST: next_state = T0;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1;
        next_state = T1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1;
        next_state = T2;
      end
      T2: begin
        Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) next_state = T3;
      end
      T3: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = T4;
      end
      T4: begin
        case (cls)
          CL_RFMT, CL_IMM: begin
            ro_en = 1'b1; ro_sel = rb; Yin = 1'b1; next_state = T5;
          end
          CL_UNARY: begin
            ro_en = 1'b1; ro_sel = rb; operation = alu; Zin_low = 1'b1;
            next_state = T5;
          end
          CL_MULDIV: begin
            ro_en = 1'b1; ro_sel = ra; Yin = 1'b1; next_state = T5;
          end
          CL_HALT:    next_state = HALT;
          CL_ILLEGAL: begin illegal = 1'b1; instr_end = 1'b1; end
          default:    instr_end = 1'b1;
        endcase
      end
      T5: begin
        case (cls)
          CL_RFMT: begin
            ro_en = 1'b1; ro_sel = rc; operation = alu; Zin_low = 1'b1;
            next_state = T6;
          end
          CL_IMM: begin
            Cout = 1'b1; operation = alu; Zin_low = 1'b1; next_state = T6;
          end
          CL_UNARY: begin
            Zlowout = 1'b1; ri_en = 1'b1; ri_sel = ra; instr_end = 1'b1;
          end
          CL_MULDIV: begin
            ro_en = 1'b1; ro_sel = rb; operation = alu;
            Zin_low = 1'b1; Zin_high = 1'b1; next_state = T6;
          end
          default: instr_end = 1'b1;
        endcase
      end
      T6: begin
        Zlowout = 1'b1;
        if (cls == CL_MULDIV) begin
          LOin = 1'b1; next_state = T7;
        end else begin
          ri_en = 1'b1; ri_sel = ra; instr_end = 1'b1;
        end
      end
      T7: begin
        Zhighout = 1'b1; HIin = 1'b1; instr_end = 1'b1;
      end
      HALT:    next_state = HALT;
      default: next_state = RST;
    endcase

    // stop is honoured only on the last edge of an instruction.
    if (instr_end) next_state = stop ? HALT : T0;
  end

  assign run   = (state_q != RST) && (state_q != HALT);
  assign state = state_q;

  reg_select u_rout (.en(ro_en), .sel(ro_sel), .onehot(R_out));
  reg_select u_rin  (.en(ri_en), .sel(ri_sel), .onehot(R_in));

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: stimulus queues per-cycle expected output vectors, a negedge monitor compares.
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b1;
  logic        stop = 1'b0;
  logic        run, illegal;
  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin;
  logic [15:0] R_out, R_in;
  logic [3:0]  operation, state;

  control_unit dut (
    .Clock(Clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .run(run), .illegal(illegal),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
    .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Zin_low(Zin_low), .Zin_high(Zin_high),
    .HIin(HIin), .LOin(LOin),
    .R_out(R_out), .R_in(R_in), .operation(operation), .state(state)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]  st;
    logic        run;
    logic        ill;
    logic [6:0]  src;   // PCout Zlowout Zhighout HIout LOout MDRout Cout
    logic [10:0] ld;    // MARin PCin MDRin IRin Yin IncPC Read Zin_low Zin_high HIin LOin
    logic [15:0] ro;
    logic [15:0] ri;
    logic [3:0]  op;
  } exp_t;

  localparam logic [6:0]  S_PC  = 7'b1000000;
  localparam logic [6:0]  S_ZL  = 7'b0100000;
  localparam logic [6:0]  S_ZH  = 7'b0010000;
  localparam logic [6:0]  S_MDR = 7'b0000010;
  localparam logic [6:0]  S_C   = 7'b0000001;
  localparam logic [10:0] L_MAR = 11'b10000000000;
  localparam logic [10:0] L_PCI = 11'b01000000000;
  localparam logic [10:0] L_MDI = 11'b00100000000;
  localparam logic [10:0] L_IRI = 11'b00010000000;
  localparam logic [10:0] L_Y   = 11'b00001000000;
  localparam logic [10:0] L_INC = 11'b00000100000;
  localparam logic [10:0] L_RD  = 11'b00000010000;
  localparam logic [10:0] L_ZL  = 11'b00000001000;
  localparam logic [10:0] L_ZH  = 11'b00000000100;
  localparam logic [10:0] L_HI  = 11'b00000000010;
  localparam logic [10:0] L_LO  = 11'b00000000001;

  localparam logic [31:0] IR_ADD  = 32'h18918000;  // ADD R1,R2,R3
  localparam logic [31:0] IR_MUL  = 32'h7A280000;  // MUL R4,R5
  localparam logic [31:0] IR_ADDI = 32'h610FFFFB;  // ADDI R2,R1,-5
  localparam logic [31:0] IR_NOT  = {5'b10010, 4'd3, 4'd6, 19'd0};  // NOT R3,R6
  localparam logic [31:0] IR_BAD  = {5'b11111, 27'd0};
  localparam logic [31:0] IR_NOP  = {5'b11010, 27'd0};
  localparam logic [31:0] IR_HLT  = {5'b11011, 27'd0};

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(input state_t s, input logic [6:0] src, input logic [10:0] ld,
                              input logic [15:0] ro, input logic [15:0] ri,
                              input logic [3:0] op, input logic ill);
    exp_t e;
    e.st  = s;
    e.run = (s != RST) && (s != HALT);
    e.ill = ill;
    e.src = src;
    e.ld  = ld;
    e.ro  = ro;
    e.ri  = ri;
    e.op  = op;
    return e;
  endfunction

  // Sets the inputs for the coming edge and queues the expectation for the cycle just entered.
  task automatic cyc(input exp_t e, input logic mr, input logic stp);
    @(posedge Clock);
    #1;
    mem_ready = mr;
    stop      = stp;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    clear = 1'b0;
    q.push_back(mk(RST, 0, 0, 0, 0, 0, 0));
    @(posedge Clock);
    #1;
    clear = 1'b1;
    q.push_back(mk(RST, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic fetch(input logic [31:0] iv, input int stall, input logic stp3);
    cyc(mk(T0, S_PC, L_MAR | L_INC | L_ZL, 0, 0, 0, 0), 1'b1, 1'b0);
    ir = iv;
    cyc(mk(T1, S_ZL, L_PCI, 0, 0, 0, 0), 1'b1, 1'b0);
    for (int i = 0; i < stall; i++)
      cyc(mk(T2, 0, L_RD | L_MDI, 0, 0, 0, 0), 1'b0, 1'b0);
    cyc(mk(T2, 0, L_RD | L_MDI, 0, 0, 0, 0), 1'b1, 1'b0);
    cyc(mk(T3, S_MDR, L_IRI, 0, 0, 0, 0), 1'b1, stp3);
  endtask

  task automatic add_body(input logic stp6);
    cyc(mk(T4, 0, L_Y, 16'h0004, 0, 4'd0, 0), 1'b1, 1'b0);
    cyc(mk(T5, 0, L_ZL, 16'h0008, 0, 4'd0, 0), 1'b1, 1'b0);
    cyc(mk(T6, S_ZL, 0, 0, 16'h0002, 4'd0, 0), 1'b1, stp6);
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {state, run, illegal,
             {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout},
             {MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin},
             R_out, R_in, operation};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_check #%0d @%0t: state act=%0d exp=%0d; vector act=%h exp=%h",
                   total, $time, a.st, e.st, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    do_reset();

    fetch(IR_ADD, 0, 1'b0);
    add_body(1'b0);

    // ADD cut short by clear during T5
    fetch(IR_ADD, 0, 1'b0);
    cyc(mk(T4, 0, L_Y, 16'h0004, 0, 4'd0, 0), 1'b1, 1'b0);
    do_reset();

    // MUL with a three-cycle memory stall
    fetch(IR_MUL, 3, 1'b0);
    cyc(mk(T4, 0, L_Y, 16'h0010, 0, 4'd0, 0), 1'b1, 1'b0);
    cyc(mk(T5, 0, L_ZL | L_ZH, 16'h0020, 0, 4'd8, 0), 1'b1, 1'b0);
    cyc(mk(T6, S_ZL, L_LO, 0, 0, 4'd0, 0), 1'b1, 1'b0);
    cyc(mk(T7, S_ZH, L_HI, 0, 0, 4'd0, 0), 1'b1, 1'b0);

    fetch(IR_ADDI, 0, 1'b0);
    cyc(mk(T4, 0, L_Y, 16'h0002, 0, 4'd0, 0), 1'b1, 1'b0);
    cyc(mk(T5, S_C, L_ZL, 0, 0, 4'd0, 0), 1'b1, 1'b0);
    cyc(mk(T6, S_ZL, 0, 0, 16'h0004, 4'd0, 0), 1'b1, 1'b0);

    fetch(IR_NOT, 0, 1'b0);
    cyc(mk(T4, 0, L_ZL, 16'h0040, 0, 4'd11, 0), 1'b1, 1'b0);
    cyc(mk(T5, S_ZL, 0, 0, 16'h0008, 4'd0, 0), 1'b1, 1'b0);

    fetch(IR_BAD, 0, 1'b0);
    cyc(mk(T4, 0, 0, 0, 0, 4'd0, 1), 1'b1, 1'b0);

    // stop asserted at a non-final edge must be ignored
    fetch(IR_NOP, 0, 1'b1);
    cyc(mk(T4, 0, 0, 0, 0, 4'd0, 0), 1'b1, 1'b0);

    fetch(IR_ADD, 0, 1'b0);
    add_body(1'b1);
    for (int i = 0; i < 20; i++)
      cyc(mk(HALT, 0, 0, 0, 0, 0, 0), i[0], 1'b0);

    do_reset();
    fetch(IR_HLT, 0, 1'b0);
    cyc(mk(T4, 0, 0, 0, 0, 4'd0, 0), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(mk(HALT, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);

    @(negedge Clock);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: entries left act=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencer for the single-bus CPU datapath. It runs a multi-cycle fetch/decode/execute cycle and generates every datapath enable: register in/out strobes, bus source selects, the ALU operation code and the memory read handshake. It sits beside the datapath and watches the IR contents. It supports fetch with a memory-ready stall, three-register ALU ops, immediate ALU ops, unary ops, MUL/DIV to HI/LO, NOP and HALT.

## Interface
Parameters:
- none; opcodes, ALU codes and state encodings live in the package.

Ports (name, direction, width, meaning):
- Clock  in  1  single system clock; all state changes on rising edge
- clear  in  1  asynchronous, active-low reset
- ir  in  32  IR register contents; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc, [18:0] C
- mem_ready  in  1  memory data valid on Mdatain
- stop  in  1  halt request, honoured at instruction boundary
- run  out  1  high while sequencing (not RST/HALT)
- illegal  out  1  one-cycle pulse on an undefined opcode
- PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout  out  1 each  bus source selects, at most one high per cycle
- MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Zin_low, Zin_high, HIin, LOin  out  1 each  load/strobe enables
- R_out  out  16  one-hot general-register bus select (bit n = Rn)
- R_in  out  16  one-hot general-register load
- operation  out  4  ALU opcode
- state  out  4  current state encoding (debug)

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- Outputs are a combinational decode of the state register and ir. Any output not listed for a state is 0.
- RST: all outputs 0, run=0. Next state is T0.
- T0: PCout, MARin, IncPC, Zin_low.
- T1: Zlowout, PCin.
- T2: Read, MDRin. Hold T2 while mem_ready=0. Advance on the edge where mem_ready=1.
- T3: MDRout, IRin.
- R-format (ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHL 01010):
  - T4: R_out[Rb], Yin.
  - T5: R_out[Rc], operation=ALU code, Zin_low.
  - T6: Zlowout, R_in[Ra].
- Immediate (ADDI 01100, ANDI 01101, ORI 01110; uses ADD/AND/OR ALU codes):
  - T4: R_out[Rb], Yin.
  - T5: Cout, operation, Zin_low.
  - T6: Zlowout, R_in[Ra].
- Unary (NEG 10001, NOT 10010):
  - T4: R_out[Rb], operation, Zin_low.
  - T5: Zlowout, R_in[Ra]. Instruction ends here.
- MUL 01111 / DIV 10000:
  - T4: R_out[Ra], Yin.
  - T5: R_out[Rb], operation, Zin_low, Zin_high.
  - T6: Zlowout, LOin.
  - T7: Zhighout, HIin.
- NOP 11010: ends at T4 with no strobes.
- HALT 11011: T4 goes to HALT.
- Any other opcode: illegal=1 in T4, then treated as NOP.
- Instruction end: next state is T0. If stop=1 at that edge, next state is HALT instead.
- HALT: all outputs 0, run=0. Exits only via clear.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, ROR 4, ROL 5, SHR 6, SHL 7, MUL 8, DIV 9, NEG 10, NOT 11.

## Timing
- clear low forces RST asynchronously, from any state including mid-fetch, stall or execute. Outputs go to 0 immediately.
- First T0 occurs on the first rising edge after clear rises.
- Latency with mem_ready=1 throughout:
  - fetch: 4 cycles (T0–T3)
  - R-format / immediate: 7 cycles total
  - unary: 6 cycles
  - MUL/DIV: 8 cycles
  - NOP / illegal: 5 cycles
- Each cycle mem_ready=0 in T2 adds one cycle. Read and MDRin stay high continuously during the stall.
- stop is sampled only on the final-state edge. stop pulses at other times are ignored.
- At most one bus source select (including R_out) is high in any cycle.

## Structure
- Package cpu_ctrl_pkg holds:
  - 5-bit opcode constants
  - 4-bit ALU codes
  - state enum
  - IR field bit positions
- One sub-module, reg_select: 4-to-16 one-hot decoder with an enable, instantiated twice (R_out, R_in).
- Top module holds the state register, next-state logic and output decode (roughly 200–300 lines).

## Test plan
- Reset: assert clear low mid-T5 of an ADD.
  - Required: all outputs 0 and state=RST immediately.
  - After release, the next cycle shows PCout=MARin=IncPC=Zin_low=1.
- ADD R1,R2,R3 (ir=32'h18918000), mem_ready=1:
  - T4: R_out=16'h0004, Yin=1.
  - T5: R_out=16'h0008, operation=0, Zin_low=1.
  - T6: Zlowout=1, R_in=16'h0002.
  - T0 follows 7 cycles after the start.
- Stall: mem_ready=0 for 3 cycles in T2.
  - Required: Read=MDRin=1 for 4 cycles; IRin=1 only in the following cycle.
- MUL R4,R5 (ir=32'h7A280000):
  - T4: R_out=16'h0010.
  - T5: R_out=16'h0020, operation=8, Zin_low=Zin_high=1.
  - T6: LOin=1.
  - T7: HIin=1.
- ADDI R2,R1,-5 (ir=32'h610FFFFB):
  - T5: Cout=1, operation=0.
  - T6: R_in=16'h0004.
- Illegal, stop and HALT:
  - Opcode 11111: illegal pulses 1 cycle in T4, then T0.
  - stop=1 at an ADD's T6 edge: next state HALT, run=0, held for 20 cycles.
  - ir opcode 11011: same HALT result.
